// File: rtl/spi_pkg.sv
// Shared SPI definitions for the transmitter and the SPI trigger receiver.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FRONT,
    SHIFT,
    BACK
  } state_t;

  localparam int unsigned SCLK_DIV_DEFAULT = 32;

  localparam logic LEN8  = 1'b0;
  localparam logic LEN16 = 1'b1;

endpackage

// File: rtl/spi_tx_halfbit_cnt.sv
// Half-period counter: counts 0..H-1 while not cleared, ticks for one cycle at H-1.
module spi_tx_halfbit_cnt #(
  parameter int unsigned H = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (H > 1) ? $clog2(H) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == CW'(H - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clr && (cnt == CW'(H - 1));

endmodule

// File: rtl/spi_tx_protocol.sv
// SPI master transmitter: frames one 8/16-bit word MSB first on SS_n/SCLK/MOSI.
module spi_tx_protocol
  import spi_pkg::*;
#(
  parameter int unsigned SCLK_DIV = SCLK_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data,
  input  logic        len8_16,
  input  logic        edg,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        busy,
  output logic        done
);

  localparam int unsigned H = SCLK_DIV / 2;

  state_t      state;
  logic [15:0] sr;
  logic        len16_q;
  logic        edg_q;
  logic [4:0]  edge_cnt;
  logic [4:0]  last_edge;
  logic        tick;

  spi_tx_halfbit_cnt #(
    .H(H)
  ) u_halfbit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE),
    .tick(tick)
  );

  // edge_cnt holds toggles already made; 2N-1 (not 2N) marks the final
  // toggle so a 32-toggle frame still fits in 5 bits.
  assign last_edge = len16_q ? 5'd31 : 5'd15;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      len16_q  <= LEN8;
      edg_q    <= 1'b0;
      edge_cnt <= '0;
      SS_n     <= 1'b1;
      SCLK     <= 1'b1;
      MOSI     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr       <= (len8_16 == LEN16) ? data : {data[7:0], 8'h00};
            MOSI     <= (len8_16 == LEN16) ? data[15] : data[7];
            len16_q  <= len8_16;
            edg_q    <= edg;
            edge_cnt <= '0;
            SS_n     <= 1'b0;
            busy     <= 1'b1;
            state    <= FRONT;
          end
        end
        FRONT: begin
          if (tick) begin
            SCLK     <= 1'b0;
            edge_cnt <= 5'd1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            SCLK     <= ~SCLK;
            edge_cnt <= edge_cnt + 5'd1;
            // The first falling toggle happens in FRONT, so every falling
            // toggle seen here is a legal shift point for edg=1.
            if ((edg_q && SCLK) || (!edg_q && !SCLK && (edge_cnt != last_edge))) begin
              sr   <= {sr[14:0], 1'b0};
              MOSI <= sr[14];
            end
            if (edge_cnt == last_edge) begin
              edge_cnt <= '0;
              state    <= BACK;
            end
          end
        end
        BACK: begin
          if (tick) begin
            SS_n  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            MOSI  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_protocol.sv
// Scoreboard bench for spi_tx_protocol: stimulus queues expected frames, a monitor decodes the wire.
module tb_spi_tx_protocol;
  import spi_pkg::*;

  localparam int unsigned SCLK_DIV = 32;
  localparam int unsigned H        = SCLK_DIV / 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data;
  logic        len8_16;
  logic        edg;
  logic        SS_n, SCLK, MOSI, busy, done;

  spi_tx_protocol #(
    .SCLK_DIV(SCLK_DIV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .data   (data),
    .len8_16(len8_16),
    .edg    (edg),
    .SS_n   (SS_n),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] word;
    int unsigned n;
    logic        edg;
    int unsigned t0;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_frames = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Called at posedge+1; start is sampled at the next edge.
  task automatic send(input logic [15:0] d, input logic l, input logic e);
    exp_t x;
    start   = 1'b1;
    data    = d;
    len8_16 = l;
    edg     = e;
    if (!busy && !rst) begin
      x.word = (l == LEN16) ? d : {8'h00, d[7:0]};
      x.n    = (l == LEN16) ? 16 : 8;
      x.edg  = e;
      x.t0   = cyc;
      exp_q.push_back(x);
    end
    @(posedge clk); #1;
    start   = 1'b0;
    data    = 16'($urandom);
    len8_16 = 1'($urandom);
    edg     = 1'($urandom);
  endtask

  task automatic wait_idle();
    int unsigned k = 0;
    while ((busy || exp_q.size() != 0) && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 2000) flag("idle_timeout");
  endtask

  task automatic wait_done();
    int unsigned k = 0;
    while (!done && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 2000) flag("done_timeout");
  endtask

  // Monitor: decodes frames from the pins and pops the scoreboard on done.
  exp_t        cur;
  logic        in_frame = 1'b0;
  logic        prev_ss = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0;
  logic        have_sample = 1'b0;
  logic [15:0] rx;
  int unsigned nbits, rises, busy_cnt, last_sample, last_chg;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (prev_ss && !SS_n) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_frame");
        end else begin
          cur = exp_q[0];
          chk("ss_fall_cycle", cyc, cur.t0 + 1);
          in_frame    = 1'b1;
          nbits       = 0;
          rises       = 0;
          busy_cnt    = 0;
          rx          = '0;
          have_sample = 1'b0;
        end
      end
      if (in_frame) begin
        if (busy) busy_cnt++;
        if (MOSI !== prev_mosi && have_sample)
          chk("mosi_hold_after", 32'(cyc - last_sample >= H - 1), 1);
        if (!SS_n && !prev_sclk && SCLK) rises++;
        if (!SS_n && ((cur.edg && !prev_sclk && SCLK) || (!cur.edg && prev_sclk && !SCLK))) begin
          chk("mosi_hold_before", 32'(cyc - last_chg >= H - 1), 1);
          rx          = {rx[14:0], MOSI};
          nbits++;
          last_sample = cyc;
          have_sample = 1'b1;
        end
      end
      if (done) begin
        if (!in_frame) begin
          flag("unexpected_done");
        end else begin
          chk("word", rx, cur.word);
          chk("nbits", nbits, cur.n);
          chk("rises_while_ss", rises, cur.n);
          chk("done_cycle", cyc, cur.t0 + 1 + (2 * cur.n + 1) * H);
          chk("busy_cycles", busy_cnt, (2 * cur.n + 1) * H);
          chk("busy_at_done", busy, 0);
          chk("ss_at_done", SS_n, 1);
          void'(exp_q.pop_front());
          in_frame = 1'b0;
          n_frames++;
        end
      end
    end
    if (MOSI !== prev_mosi) last_chg = cyc;
    prev_ss   = SS_n;
    prev_sclk = SCLK;
    prev_mosi = MOSI;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ss_n"}, SS_n, 1);
    chk({tag, "_sclk"}, SCLK, 1);
    chk({tag, "_mosi"}, MOSI, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int frames_before;
    rst     = 1'b1;
    start   = 1'b0;
    data    = '0;
    len8_16 = LEN8;
    edg     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    send(16'h00A5, LEN8, 1'b1);
    wait_idle();
    send(16'hC3F0, LEN16, 1'b0);
    wait_idle();
    send(16'h1234, LEN16, 1'b1);
    wait_idle();
    send(16'h1235, LEN16, 1'b1);
    wait_idle();

    // Second start mid-frame is ignored; next start lands on the done cycle.
    frames_before = n_frames;
    send(16'h3C96, LEN8, 1'b0);
    repeat (49) begin @(posedge clk); #1; end
    send(16'hFFFF, LEN16, 1'b1);
    wait_done();
    send(16'h8001, LEN16, 1'b0);
    wait_idle();
    chk("frames_ignore_b2b", n_frames - frames_before, 2);

    // Reset 100 cycles into a 16-bit frame.
    send(16'hBEEF, LEN16, 1'b1);
    repeat (99) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk_reset_outputs("midrst");
    rst = 1'b0;
    repeat (2 * H) begin @(posedge clk); #1; end
    send(16'h5AA5, LEN16, 1'b0);
    wait_idle();

    repeat (6) begin
      send(16'($urandom), 1'($urandom), 1'($urandom));
      wait_idle();
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
